// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU: op codes, FSM states and
// small decode helpers used by both the slice and the top level.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    // True for every op code the datapath knows how to execute.
    function automatic logic op_is_legal(input logic [2:0] op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_XOR) ||
               (op == OP_ADD) || (op == OP_SLT);
    endfunction

    // Carry fed into bit 0: ADD uses cin, SUB and SLT add the +1 of the
    // two's complement, logic ops start from zero.
    function automatic logic init_carry(input logic [2:0] op,
                                        input logic       bnegate,
                                        input logic       cin);
        logic c;
        c = 1'b0;
        if (op == OP_ADD) begin
            c = bnegate ? 1'b1 : cin;
        end else if (op == OP_SLT) begin
            c = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/alu_slice.sv
// One-bit ALU slice: logic ops and a full adder with optional B inversion.
module alu_slice
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic       bnegate,
    input  logic [2:0] op,
    output logic       sum,
    output logic       carry
);

    logic negate;
    logic bb;

    // Select B polarity and the per-op sum/carry for this bit position.
    always_comb begin
        negate = 1'b0;
        if (op == OP_ADD) begin
            negate = bnegate;
        end else if (op == OP_SLT) begin
            negate = 1'b1;
        end
        bb    = b ^ negate;
        sum   = 1'b0;
        carry = 1'b0;
        case (op)
            OP_AND: sum = a & bb;
            OP_OR:  sum = a | bb;
            OP_XOR: sum = a ^ bb;
            OP_ADD, OP_SLT: begin
                sum   = a ^ bb ^ cin;
                carry = (a & bb) | (a & cin) | (bb & cin);
            end
            default: begin
                sum   = 1'b0;
                carry = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_serial.sv
// Bit-serial ALU: one operand bit per clock through a single alu_slice,
// LSB first, with a registered carry and valid/ready on both sides.
module alu_serial
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             bnegate,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic             err
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    state_t           next_state;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [2:0]       op_r;
    logic             bneg_r;
    logic             carry_r;
    logic             cout_r;
    logic             ovf_r;
    logic             zero_r;
    logic             err_r;
    logic             accept;
    logic             last_bit;
    logic             slice_sum;
    logic             slice_carry;
    logic             last_ovf;
    logic             slt_bit;
    logic             arith_op;
    logic [WIDTH-1:0] final_res;

    alu_slice u_slice (
        .a       (a_sr[0]),
        .b       (b_sr[0]),
        .cin     (carry_r),
        .bnegate (bneg_r),
        .op      (op_r),
        .sum     (slice_sum),
        .carry   (slice_carry)
    );

    // State register; reset always returns the FSM to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: accept, step through WIDTH bits, wait for the consumer.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (accept)    next_state = S_RUN;
            S_RUN:  if (last_bit)  next_state = S_DONE;
            S_DONE: if (out_ready) next_state = S_IDLE;
            default:               next_state = S_IDLE;
        endcase
    end

    // Handshake outputs and datapath strobes decoded from the current state.
    always_comb begin
        in_ready  = (state == S_IDLE) && !reset;
        out_valid = (state == S_DONE);
        accept    = in_ready && in_valid;
        last_bit  = (state == S_RUN) && (bit_cnt == LAST_BIT);
    end

    // Value the result register takes on the final bit, including SLT and illegal-op overrides.
    always_comb begin
        arith_op  = (op_r == OP_ADD);
        last_ovf  = carry_r ^ slice_carry;
        slt_bit   = slice_sum ^ last_ovf;
        final_res = {slice_sum, res_sr[WIDTH-1:1]};
        if (op_r == OP_SLT) begin
            final_res = {{(WIDTH-1){1'b0}}, slt_bit};
        end else if (!op_is_legal(op_r)) begin
            final_res = '0;
        end
    end

    // Operand/result shift registers, carry, bit counter and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_sr    <= '0;
            b_sr    <= '0;
            res_sr  <= '0;
            op_r    <= OP_AND;
            bneg_r  <= 1'b0;
            carry_r <= 1'b0;
            bit_cnt <= '0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            zero_r  <= 1'b0;
            err_r   <= 1'b0;
        end else if (accept) begin
            a_sr    <= a;
            b_sr    <= b;
            res_sr  <= '0;
            op_r    <= op;
            bneg_r  <= bnegate;
            carry_r <= init_carry(op, bnegate, cin);
            bit_cnt <= '0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            zero_r  <= 1'b0;
            err_r   <= 1'b0;
        end else if (state == S_RUN) begin
            a_sr    <= a_sr >> 1;
            b_sr    <= b_sr >> 1;
            carry_r <= slice_carry;
            if (last_bit) begin
                res_sr <= final_res;
                cout_r <= arith_op ? slice_carry : 1'b0;
                ovf_r  <= arith_op ? last_ovf : 1'b0;
                zero_r <= (final_res == '0);
                err_r  <= !op_is_legal(op_r);
            end else begin
                res_sr  <= {slice_sum, res_sr[WIDTH-1:1]};
                bit_cnt <= bit_cnt + CW'(1);
            end
        end
    end

    assign result   = res_sr;
    assign cout     = cout_r;
    assign overflow = ovf_r;
    assign zero     = zero_r;
    assign err      = err_r;

endmodule

// File: tb/tb_alu_serial.sv
// Directed, table-driven bench for alu_serial at WIDTH=8.
module tb_alu_serial;
    import alu_pkg::*;

    localparam int WIDTH = 8;
    localparam int LATENCY = WIDTH + 1;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             bnegate;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;
    logic             zero;
    logic             err;

    typedef struct {
        string      name;
        logic [2:0] op;
        logic       bneg;
        logic       cin;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       co;
        logic       ov;
        logic       z;
        logic       e;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    alu_serial #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .bnegate   (bnegate),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .overflow  (overflow),
        .zero      (zero),
        .err       (err)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so a stuck DUT can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input string name, input logic [2:0] o,
                                input logic bn, input logic c,
                                input logic [7:0] va, input logic [7:0] vb,
                                input logic [7:0] r, input logic co,
                                input logic ov, input logic z, input logic e);
        vec_t v;
        v.name = name; v.op = o; v.bneg = bn; v.cin = c; v.a = va; v.b = vb;
        v.res = r; v.co = co; v.ov = ov; v.z = z; v.e = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one bundle, accept it, pulse in_valid during RUN, return cycles to out_valid.
    task automatic apply_stimulus(input vec_t v, input logic hold, output int lat);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check({v.name, " in_ready before accept"}, in_ready, 1'b1);
        a = v.a; b = v.b; op = v.op; bnegate = v.bneg; cin = v.cin;
        in_valid = 1'b1;
        out_ready = !hold;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
        bnegate = 1'($urandom); cin = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
            in_valid = (lat == 2) || (lat == 3);
        end
        in_valid = 1'b0;
    endtask

    // Compare the completed bundle against its record, then retire it.
    task automatic check_output(input vec_t v, input int lat, input int hold);
        check({v.name, " latency"}, 64'(lat), 64'(LATENCY));
        check({v.name, " result"}, result, v.res);
        check({v.name, " cout"}, cout, v.co);
        check({v.name, " overflow"}, overflow, v.ov);
        check({v.name, " zero"}, zero, v.z);
        check({v.name, " err"}, err, v.e);
        check({v.name, " in_ready in DONE"}, in_ready, 1'b0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({v.name, " held out_valid"}, out_valid, 1'b1);
            check({v.name, " held result"}, result, v.res);
            check({v.name, " held flags"}, {cout, overflow, zero, err}, {v.co, v.ov, v.z, v.e});
            check({v.name, " held in_ready"}, in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({v.name, " out_valid after retire"}, out_valid, 1'b0);
        check({v.name, " in_ready after retire"}, in_ready, 1'b1);
    endtask

    initial begin
        int lat;
        int acc0;
        int acc1;
        int cyc;
        int vhigh;
        bit seen;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op = OP_AND; bnegate = 1'b0; cin = 1'b0;

        vecs.push_back(mk("add_7f_01",   OP_ADD, 0, 0, 8'h7F, 8'h01, 8'h80, 0, 1, 0, 0));
        vecs.push_back(mk("add_ff_01_c", OP_ADD, 0, 1, 8'hFF, 8'h01, 8'h01, 1, 0, 0, 0));
        vecs.push_back(mk("sub_05_05",   OP_ADD, 1, 0, 8'h05, 8'h05, 8'h00, 1, 0, 1, 0));
        vecs.push_back(mk("sub_00_01",   OP_ADD, 1, 0, 8'h00, 8'h01, 8'hFF, 0, 0, 0, 0));
        vecs.push_back(mk("sub_80_01",   OP_ADD, 1, 0, 8'h80, 8'h01, 8'h7F, 1, 1, 0, 0));
        vecs.push_back(mk("sub_cin_ign", OP_ADD, 1, 1, 8'h10, 8'h03, 8'h0D, 1, 0, 0, 0));
        vecs.push_back(mk("slt_fe_01",   OP_SLT, 0, 0, 8'hFE, 8'h01, 8'h01, 0, 0, 0, 0));
        vecs.push_back(mk("slt_01_fe",   OP_SLT, 0, 0, 8'h01, 8'hFE, 8'h00, 0, 0, 1, 0));
        vecs.push_back(mk("slt_80_7f",   OP_SLT, 0, 1, 8'h80, 8'h7F, 8'h01, 0, 0, 0, 0));
        vecs.push_back(mk("slt_05_05",   OP_SLT, 0, 0, 8'h05, 8'h05, 8'h00, 0, 0, 1, 0));
        vecs.push_back(mk("and_ca_0f",   OP_AND, 0, 0, 8'hCA, 8'h0F, 8'h0A, 0, 0, 0, 0));
        vecs.push_back(mk("or_ca_0f",    OP_OR,  0, 0, 8'hCA, 8'h0F, 8'hCF, 0, 0, 0, 0));
        vecs.push_back(mk("xor_ca_0f",   OP_XOR, 0, 0, 8'hCA, 8'h0F, 8'hC5, 0, 0, 0, 0));
        vecs.push_back(mk("and_neg_ign", OP_AND, 1, 1, 8'hCA, 8'h0F, 8'h0A, 0, 0, 0, 0));
        vecs.push_back(mk("and_zero",    OP_AND, 0, 0, 8'hF0, 8'h0F, 8'h00, 0, 0, 1, 0));
        vecs.push_back(mk("illegal_110", 3'b110, 0, 0, 8'hCA, 8'h0F, 8'h00, 0, 0, 1, 1));
        vecs.push_back(mk("or_clr_err",  OP_OR,  0, 0, 8'h12, 8'h30, 8'h32, 0, 0, 0, 0));
        vecs.push_back(mk("illegal_001", 3'b001, 1, 1, 8'hFF, 8'hFF, 8'h00, 0, 0, 1, 1));
        vecs.push_back(mk("illegal_111", 3'b111, 0, 1, 8'h7F, 8'h01, 8'h00, 0, 0, 1, 1));
        vecs.push_back(mk("xor_clr_err", OP_XOR, 0, 0, 8'hFF, 8'h0F, 8'hF0, 0, 0, 0, 0));

        // Reset state.
        repeat (3) begin
            @(negedge clk);
            check("reset in_ready", in_ready, 1'b0);
            check("reset out_valid", out_valid, 1'b0);
            check("reset result", result, 8'h00);
            check("reset flags", {cout, overflow, zero, err}, 4'b0000);
        end
        reset = 1'b0;
        @(negedge clk);
        check("in_ready after reset", in_ready, 1'b1);

        // Table of directed vectors.
        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i], 1'b0, lat);
            check_output(vecs[i], lat, 0);
        end

        // Consumer stalls five cycles in DONE.
        apply_stimulus(vecs[0], 1'b1, lat);
        check_output(vecs[0], lat, 5);

        // Back-to-back with in_valid held high: accepts WIDTH+2 cycles apart.
        @(negedge clk);
        out_ready = 1'b1;
        a = 8'h10; b = 8'h20; op = OP_ADD; bnegate = 1'b0; cin = 1'b0;
        in_valid = 1'b1;
        acc0 = -1; acc1 = -1; cyc = 0; seen = 1'b0;
        for (int i = 0; i < 40 && acc1 < 0; i++) begin
            if (in_ready) begin
                if (acc0 < 0) acc0 = cyc;
                else acc1 = cyc;
            end
            if (out_valid && !seen) begin
                seen = 1'b1;
                check("b2b first result", result, 8'h30);
            end
            @(posedge clk);
            #1;
            if (acc0 >= 0 && acc1 < 0) begin
                a = 8'h0F; b = 8'hF0; op = OP_OR;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        check("b2b first result seen", seen, 1'b1);
        check("b2b accept interval", 64'(acc1 - acc0), 64'(WIDTH + 2));
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("b2b second result", result, 8'hFF);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("b2b in_ready after retire", in_ready, 1'b1);

        // Reset in the 4th RUN cycle aborts the operation.
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; op = OP_ADD; bnegate = 1'b0; cin = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("abort out_valid", out_valid, 1'b0);
            check("abort in_ready", in_ready, 1'b0);
            check("abort result", result, 8'h00);
            check("abort flags", {cout, overflow, zero, err}, 4'b0000);
        end
        reset = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check("in_ready after abort", in_ready, 1'b1);
        vhigh = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) vhigh++;
        end
        check("aborted op never valid", 64'(vhigh), 64'd0);
        apply_stimulus(mk("add_after_abort", OP_ADD, 0, 0, 8'h03, 8'h04, 8'h07, 0, 0, 0, 0), 1'b0, lat);
        check_output(mk("add_after_abort", OP_ADD, 0, 0, 8'h03, 8'h04, 8'h07, 0, 0, 0, 0), lat, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
